clause_scan_ctrl: RTL



---
 rtl/clause_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/clause_scan_ctrl.sv
// Clause scan sequencer: takes one variable assignment, reads clause memory one slice
// per request and streams the comparator bitmasks out through a 2-entry result buffer.
module clause_scan_ctrl #(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  localparam int NUM_SLICES           = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int SB                   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int MW                   = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [VAR_ID_BITS-1:0] req_var_id,
  input  logic                   req_var_val,
  input  logic                   scan_abort,
  output logic                   mem_rd_en,
  output logic [SB-1:0]          mem_rd_addr,
  output logic [VAR_ID_BITS-1:0] cmp_var_id,
  output logic                   cmp_var_val,
  input  logic [MW-1:0]          cmp_bitmask,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [MW-1:0]          res_bitmask,
  output logic [SB-1:0]          res_slice_idx,
  output logic                   res_last,
  output logic                   scan_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SB:0]   SLICE_CNT = (SB + 1)'(NUM_SLICES);
  localparam logic [SB-1:0] LAST_IDX  = SB'(NUM_SLICES - 1);

  state_t        state;
  logic [SB:0]   issue_cnt;
  logic          inflight;
  logic [SB-1:0] inflight_idx;
  logic [MW-1:0] fifo_mask [2];
  logic [SB-1:0] fifo_idx  [2];
  logic [1:0]    fifo_count;
  logic          rd_ptr;
  logic          wr_ptr;
  logic          pop;
  logic          credit;

  assign req_ready     = (state == IDLE);
  assign res_valid     = (fifo_count != 2'd0);
  assign res_bitmask   = fifo_mask[rd_ptr];
  assign res_slice_idx = fifo_idx[rd_ptr];
  assign res_last      = res_valid && (res_slice_idx == LAST_IDX);
  assign pop           = res_valid && res_ready;
  assign scan_done     = pop && res_last;

  // A slot popped this cycle is reusable immediately, so a new read can issue in the same cycle.
  assign credit      = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign mem_rd_en   = (state == SCAN) && !scan_abort && (issue_cnt < SLICE_CNT) && credit;
  assign mem_rd_addr = issue_cnt[SB-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      fifo_count   <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_mask[0] <= '0;
      fifo_mask[1] <= '0;
      fifo_idx[0]  <= '0;
      fifo_idx[1]  <= '0;
      cmp_var_id   <= '0;
      cmp_var_val  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmp_var_id  <= req_var_id;
            cmp_var_val <= req_var_val;
            issue_cnt   <= '0;
            inflight    <= 1'b0;
            fifo_count  <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          // A final pop wins over a simultaneous abort; either way the scan ends here.
          if (scan_done || scan_abort) begin
            inflight   <= 1'b0;
            fifo_count <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            state      <= IDLE;
          end else begin
            inflight     <= mem_rd_en;
            inflight_idx <= issue_cnt[SB-1:0];
            if (mem_rd_en)
              issue_cnt <= issue_cnt + 1'b1;
            if (inflight) begin
              fifo_mask[wr_ptr] <= cmp_bitmask;
              fifo_idx[wr_ptr]  <= inflight_idx;
              wr_ptr            <= ~wr_ptr;
            end
            if (pop)
              rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
